pdp8l_memtiming_gen: RTL

- Parametrised successor to the PDP-8/L core-memory timing generator.
- Produces the same nine timing strobes, with these additions:
  - every edge placement is a parameter;
  - an FPGA-clock-per-tick divider;
  - a read-pause-write (RPW) mode that holds the cycle between read and write for data-break/ISZ-style modify;
  - a pause watchdog.
- Sits between the CPU/data-break arbiter and the core/RAM interface.

---
 rtl/pdp8l_memtim_pkg.sv | 28 ++
 rtl/pdp8l_tick_div.sv | 33 +++
 rtl/pdp8l_memtiming_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdp8l_memtim_pkg.sv
// rtl/pdp8l_memtim_pkg.sv - shared state type, default edge ticks and width helper for the memory timing generator
package pdp8l_memtim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } memtim_state_t;

  localparam int DEF_TICK_DIV  = 1;
  localparam int DEF_T_RD_ON   = 25;
  localparam int DEF_T_STB_ON  = 50;
  localparam int DEF_T_STB_OFF = 60;
  localparam int DEF_T_CYC_ON  = 75;
  localparam int DEF_T_CYD_OFF = 85;
  localparam int DEF_T_INH_ON  = 95;
  localparam int DEF_T_WR_ON   = 100;
  localparam int DEF_T_CYC_OFF = 115;
  localparam int DEF_T_WR_OFF  = 150;
  localparam int DEF_T_END     = 160;
  localparam int DEF_PAUSE_MAX = 1000;

  // Counters that only ever need one state still get a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pdp8l_tick_div.sv
// rtl/pdp8l_tick_div.sv - CSTEP-qualified clock divider emitting one tick pulse every TICK_DIV enabled clocks
module pdp8l_tick_div
  import pdp8l_memtim_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cstep,
  input  logic i_clr,
  output logic o_tick
);

  localparam int DW = cnt_width(TICK_DIV);
  localparam logic [DW-1:0] C_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else if (i_cstep) begin
      if (i_clr || (r_div == C_LAST)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_tick = i_cstep & (r_div == C_LAST);

endmodule

// File: rtl/pdp8l_memtiming_gen.sv
// rtl/pdp8l_memtiming_gen.sv - parametrised PDP-8/L core-memory timing generator with RPW pause and watchdog
// Optional build macro MEMTIM_PENDQ_EN adds a one-deep pending start request.
module pdp8l_memtiming_gen
  import pdp8l_memtim_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int T_RD_ON   = DEF_T_RD_ON,
  parameter int T_STB_ON  = DEF_T_STB_ON,
  parameter int T_STB_OFF = DEF_T_STB_OFF,
  parameter int T_CYC_ON  = DEF_T_CYC_ON,
  parameter int T_CYD_OFF = DEF_T_CYD_OFF,
  parameter int T_INH_ON  = DEF_T_INH_ON,
  parameter int T_WR_ON   = DEF_T_WR_ON,
  parameter int T_CYC_OFF = DEF_T_CYC_OFF,
  parameter int T_WR_OFF  = DEF_T_WR_OFF,
  parameter int T_END     = DEF_T_END,
  parameter int PAUSE_MAX = DEF_PAUSE_MAX
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic CSTEP,
  input  logic memstart,
  input  logic select,
  input  logic rpw,
  input  logic wrgo,
  output logic memenab,
  output logic read,
  output logic strobe,
  output logic lock,
  output logic cycdone,
  output logic cycle,
  output logic inhibit,
  output logic write,
  output logic memdone,
  output logic busy,
  output logic pausing,
  output logic pause_tmo,
  output logic start_pend
);

  localparam int CW = cnt_width(T_END + 1);
  localparam int PW = cnt_width(PAUSE_MAX + 1);

  localparam logic [CW-1:0] C_RD_ON   = CW'(T_RD_ON);
  localparam logic [CW-1:0] C_STB_ON  = CW'(T_STB_ON);
  localparam logic [CW-1:0] C_STB_OFF = CW'(T_STB_OFF);
  localparam logic [CW-1:0] C_CYC_ON  = CW'(T_CYC_ON);
  localparam logic [CW-1:0] C_CYD_OFF = CW'(T_CYD_OFF);
  localparam logic [CW-1:0] C_INH_ON  = CW'(T_INH_ON);
  localparam logic [CW-1:0] C_WR_ON   = CW'(T_WR_ON);
  localparam logic [CW-1:0] C_CYC_OFF = CW'(T_CYC_OFF);
  localparam logic [CW-1:0] C_WR_OFF  = CW'(T_WR_OFF);
  localparam logic [CW-1:0] C_END     = CW'(T_END);
  localparam logic [PW-1:0] C_PMAX    = PW'(PAUSE_MAX);

  if (!(TICK_DIV >= 1 && TICK_DIV <= 255 && PAUSE_MAX >= 1 && T_RD_ON >= 1 &&
        T_RD_ON < T_STB_ON && T_STB_ON < T_CYC_ON && T_CYC_ON < T_WR_ON &&
        T_STB_ON < T_STB_OFF && T_CYC_ON < T_CYD_OFF && T_CYC_ON < T_CYC_OFF &&
        T_INH_ON < T_WR_OFF && T_WR_ON < T_WR_OFF && T_WR_OFF < T_END &&
        T_STB_OFF < T_END && T_CYD_OFF < T_END && T_CYC_OFF < T_END)) begin : g_param_err
    $error("pdp8l_memtiming_gen: illegal timing edge parameters");
  end

  memtim_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pcnt;
  logic          r_rpw;
  logic          r_memenab, r_read, r_strobe, r_lock, r_cycdone;
  logic          r_cycle, r_inhibit, r_write, r_memdone;
  logic          r_busy, r_pausing, r_pause_tmo;

  logic          w_tick;
  logic          w_req;
  logic          w_req_go;
  logic          w_req_rpw;
  logic          w_accept;
  logic [PW-1:0] w_pcnt_nxt;

  assign w_req      = memstart & select;
  assign w_accept   = CSTEP & (r_state == IDLE) & w_req_go;
  assign w_pcnt_nxt = r_pcnt + 1'b1;

`ifdef MEMTIM_PENDQ_EN
  logic r_pend;
  logic r_pend_rpw;

  // A request arriving while busy is parked and replayed on the first idle clock.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_pend     <= 1'b0;
      r_pend_rpw <= 1'b0;
    end else if (CSTEP) begin
      if (w_accept) begin
        r_pend <= 1'b0;
      end else if ((r_state != IDLE) && w_req && !r_pend) begin
        r_pend     <= 1'b1;
        r_pend_rpw <= rpw;
      end
    end
  end

  assign w_req_go   = w_req | r_pend;
  assign w_req_rpw  = r_pend ? r_pend_rpw : rpw;
  assign start_pend = r_pend;
`else
  assign w_req_go   = w_req;
  assign w_req_rpw  = rpw;
  assign start_pend = 1'b0;
`endif

  pdp8l_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .i_clk  (CLOCK),
    .i_rst_n(RESET_N),
    .i_cstep(CSTEP),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pcnt      <= '0;
      r_rpw       <= 1'b0;
      r_memenab   <= 1'b0;
      r_read      <= 1'b0;
      r_strobe    <= 1'b0;
      r_lock      <= 1'b0;
      r_cycdone   <= 1'b0;
      r_cycle     <= 1'b0;
      r_inhibit   <= 1'b0;
      r_write     <= 1'b0;
      r_memdone   <= 1'b0;
      r_busy      <= 1'b0;
      r_pausing   <= 1'b0;
      r_pause_tmo <= 1'b0;
    end else if (CSTEP) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_memenab   <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= CW'(1);
            r_rpw       <= w_req_rpw;
            r_pause_tmo <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_RD_ON) begin
              r_read <= 1'b1;
              r_lock <= 1'b1;
            end
            if (r_cnt == C_STB_ON)  r_strobe <= 1'b1;
            if (r_cnt == C_STB_OFF) r_strobe <= 1'b0;
            if (r_cnt == C_CYC_ON) begin
              r_read    <= 1'b0;
              r_cycdone <= 1'b1;
              r_cycle   <= 1'b1;
              // Read-pause-write: hold here with cnt parked one past the pause point.
              if (r_rpw) begin
                r_state   <= PAUSE;
                r_pausing <= 1'b1;
                r_pcnt    <= '0;
              end
            end
            if (r_cnt == C_CYD_OFF) r_cycdone <= 1'b0;
            if (r_cnt == C_INH_ON)  r_inhibit <= 1'b1;
            if (r_cnt == C_WR_ON) begin
              r_lock  <= 1'b0;
              r_write <= 1'b1;
            end
            if (r_cnt == C_CYC_OFF) r_cycle <= 1'b0;
            if (r_cnt == C_WR_OFF) begin
              r_inhibit <= 1'b0;
              r_write   <= 1'b0;
              r_memdone <= 1'b1;
            end
            if (r_cnt == C_END) begin
              r_memdone <= 1'b0;
              r_memenab <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        PAUSE: begin
          if (w_tick) begin
            if (wrgo) begin
              r_state   <= RUN;
              r_pausing <= 1'b0;
              r_pcnt    <= '0;
            end else if (w_pcnt_nxt == C_PMAX) begin
              r_state     <= RUN;
              r_pausing   <= 1'b0;
              r_pcnt      <= '0;
              r_pause_tmo <= 1'b1;
            end else begin
              r_pcnt <= w_pcnt_nxt;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign memenab   = r_memenab;
  assign read      = r_read;
  assign strobe    = r_strobe;
  assign lock      = r_lock;
  assign cycdone   = r_cycdone;
  assign cycle     = r_cycle;
  assign inhibit   = r_inhibit;
  assign write     = r_write;
  assign memdone   = r_memdone;
  assign busy      = r_busy;
  assign pausing   = r_pausing;
  assign pause_tmo = r_pause_tmo;

endmodule
